// File: rtl/avg_pkg.sv
// Shared types and decode helpers for the vector-generator state sequencer.
package avg_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_LOOKUP,
      SEQ_WAITP,
      SEQ_EXEC,
      SEQ_FETCH,
      SEQ_DRAWW
   } seq_state_t;

   typedef enum logic [1:0] {
      ACT_NOP,
      ACT_LATCH,
      ACT_STROBE,
      ACT_HALT
   } act_t;

   // Strobe index that starts a vector draw and therefore waits on the timer.
   localparam logic [1:0] ST_DRAW = 2'd2;

   // Classify a PROM next-state nibble into the action it triggers.
   function automatic act_t decode_action(input logic [3:0] ns);
      act_t act;
      if (ns[3])                act = ACT_LATCH;
      else if (ns[2])           act = ACT_STROBE;
      else if (ns[1:0] == 2'b00) act = ACT_HALT;
      else                      act = ACT_NOP;
      return act;
   endfunction

endpackage

// File: rtl/avg_step_watchdog.sv
// Counts PROM steps since the last go and flags the step that hits the limit.
module avg_step_watchdog
   import avg_pkg::*;
#(
   parameter int WDOG_MAX = 4095
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic step,
   output logic hit
);

   localparam int CNT_W = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX + 1);
   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(WDOG_MAX);

   logic [CNT_W-1:0] cnt_q;

   // Step counter: cleared on go/soft reset, bumped once per LOOKUP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  cnt_q <= '0;
      else if (clr)  cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + CNT_W'(1);
   end

   // A limit of zero disables the watchdog entirely.
   assign hit = (WDOG_MAX != 0) && (cnt_q == MAX_V);

endmodule

// File: rtl/avg_state_sequencer.sv
// Vector-generator sequencer: walks the state PROM, fetches vector-RAM bytes
// into the data latches, and fires action strobes toward the DAC/timer path.
//
//  state  | meaning
//  IDLE   | halted, waiting for go
//  LOOKUP | PROM read issued at {0, opcode, state}
//  WAITP  | PROM registering; next state captured at end of cycle
//  EXEC   | apply next state, decode action, fire strobe
//  FETCH  | vram_req held at pc until vram_ack
//  DRAWW  | wait for the vector timer to go idle
module avg_state_sequencer
   import avg_pkg::*;
#(
   parameter int              PC_W     = 13,
   parameter logic [PC_W-1:0] START_PC = '0,
   parameter int              WDOG_MAX = 4095
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            go,
   input  logic            vg_rst,
   output logic            halted,
   output logic            wdog_trip,
   output logic [7:0]      prom_addr,
   output logic            prom_cs,
   input  logic [3:0]      prom_data,
   output logic [PC_W-1:0] vram_addr,
   output logic            vram_req,
   input  logic            vram_ack,
   input  logic [7:0]      vram_data,
   output logic [7:0]      dlatch0,
   output logic [7:0]      dlatch1,
   output logic [7:0]      dlatch2,
   output logic [7:0]      dlatch3,
   output logic [2:0]      opcode,
   output logic [3:0]      strobe,
   input  logic            draw_busy
);

   seq_state_t      fsm_q, fsm_d;
   logic [3:0]      state_q;
   logic [3:0]      ns_q;
   logic [PC_W-1:0] pc_q;
   logic            trip_q;
   logic [7:0]      dlatch_q [4];
   act_t            act;
   logic            wd_hit;
   logic            wd_clr;
   logic            wd_step;

   assign act     = decode_action(ns_q);
   assign wd_clr  = vg_rst | ((fsm_q == SEQ_IDLE) & go);
   assign wd_step = (fsm_q == SEQ_LOOKUP);

   avg_step_watchdog #(.WDOG_MAX(WDOG_MAX)) u_wdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (wd_clr),
      .step    (wd_step),
      .hit     (wd_hit)
   );

   // Next-state and per-cycle strobes; soft reset overrides everything.
   always_comb begin
      fsm_d   = fsm_q;
      prom_cs = 1'b0;
      strobe  = 4'b0000;
      unique case (fsm_q)
         SEQ_IDLE:   if (go) fsm_d = SEQ_LOOKUP;
         SEQ_LOOKUP: begin
            prom_cs = 1'b1;
            fsm_d   = SEQ_WAITP;
         end
         SEQ_WAITP:  fsm_d = SEQ_EXEC;
         SEQ_EXEC: begin
            if (wd_hit) begin
               fsm_d = SEQ_IDLE;
            end else begin
               unique case (act)
                  ACT_LATCH:  fsm_d = SEQ_FETCH;
                  ACT_STROBE: begin
                     strobe = 4'b0001 << ns_q[1:0];
                     fsm_d  = (ns_q[1:0] == ST_DRAW) ? SEQ_DRAWW : SEQ_LOOKUP;
                  end
                  ACT_HALT:   fsm_d = SEQ_IDLE;
                  default:    fsm_d = SEQ_LOOKUP;
               endcase
            end
         end
         SEQ_FETCH:  if (vram_ack)   fsm_d = SEQ_LOOKUP;
         SEQ_DRAWW:  if (!draw_busy) fsm_d = SEQ_LOOKUP;
         default:    fsm_d = SEQ_IDLE;
      endcase
      if (vg_rst) fsm_d = SEQ_IDLE;
   end

   // Sequencer registers: go reload, PROM capture, state update, byte fetch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q    <= SEQ_IDLE;
         state_q  <= '0;
         ns_q     <= '0;
         pc_q     <= START_PC;
         trip_q   <= 1'b0;
         dlatch_q <= '{default: 8'h00};
      end else if (vg_rst) begin
         fsm_q    <= SEQ_IDLE;
         state_q  <= '0;
         ns_q     <= '0;
         pc_q     <= START_PC;
         trip_q   <= 1'b0;
         dlatch_q <= '{default: 8'h00};
      end else begin
         fsm_q <= fsm_d;
         case (fsm_q)
            SEQ_IDLE: if (go) begin
               pc_q    <= START_PC;
               state_q <= '0;
               trip_q  <= 1'b0;
            end
            SEQ_WAITP: ns_q <= prom_data;
            SEQ_EXEC: begin
               state_q <= ns_q;
               if (wd_hit) trip_q <= 1'b1;
            end
            SEQ_FETCH: if (vram_ack) begin
               dlatch_q[ns_q[1:0]] <= vram_data;
               pc_q                <= pc_q + PC_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Request is gated by vg_rst so it drops in the same cycle as the soft reset.
   assign halted    = (fsm_q == SEQ_IDLE);
   assign wdog_trip = trip_q;
   assign opcode    = dlatch_q[1][7:5];
   assign prom_addr = {halted, opcode, state_q};
   assign vram_addr = pc_q;
   assign vram_req  = (fsm_q == SEQ_FETCH) & ~vg_rst;
   assign dlatch0   = dlatch_q[0];
   assign dlatch1   = dlatch_q[1];
   assign dlatch2   = dlatch_q[2];
   assign dlatch3   = dlatch_q[3];

endmodule
